// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file writeback path.
package rf_pkg;

    localparam int XLEN     = 32;
    localparam int AW       = 5;
    localparam int NUM_REGS = 32;
    localparam int REG_X0   = 0;

    typedef enum logic {
        PRIO_RR    = 1'b0,
        PRIO_FIXED = 1'b1
    } prio_mode_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester grant logic: round-robin or fixed priority (req 0 highest),
// with a last-grant flop that updates on every grant in either mode.
module rr_arbiter2 #(
    parameter int PRIO_MODE = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);
    import rf_pkg::*;

    // last_q holds the index of the requester granted most recently; it
    // resets to 1 so requester 0 wins the first tie.
    logic last_q;
    logic last_d;
    logic [1:0] gnt;

    always_comb begin
        gnt = 2'b00;
        unique case (req_i)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11: begin
                if (PRIO_MODE == int'(PRIO_FIXED)) begin
                    gnt = 2'b01;
                end else begin
                    gnt = last_q ? 2'b01 : 2'b10;
                end
            end
            default: gnt = 2'b00;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (gnt[0]) begin
            last_d = 1'b0;
        end else if (gnt[1]) begin
            last_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    assign gnt_o = gnt;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file's single write port between ALU and load
// writeback, registers the winning write, drops x0 writes and forwards reads.
module regfile_wb_arbiter #(
    parameter int XLEN      = rf_pkg::XLEN,
    parameter int AW        = rf_pkg::AW,
    parameter int PRIO_MODE = 0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [AW-1:0]    req0_addr,
    input  logic [XLEN-1:0]  req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [AW-1:0]    req1_addr,
    input  logic [XLEN-1:0]  req1_data,
    output logic             req1_ready,
    output logic             we3,
    output logic [AW-1:0]    a3,
    output logic [XLEN-1:0]  wd3,
    input  logic [AW-1:0]    rd_a1,
    input  logic [AW-1:0]    rd_a2,
    input  logic [XLEN-1:0]  rf_rd1,
    input  logic [XLEN-1:0]  rf_rd2,
    output logic [XLEN-1:0]  fwd_rd1,
    output logic [XLEN-1:0]  fwd_rd2,
    output logic [CNT_W-1:0] conflict_cnt
);
    import rf_pkg::*;

    localparam logic [AW-1:0] X0_ADDR = AW'(REG_X0);

    logic [1:0]       gnt;
    logic [AW-1:0]    win_addr;
    logic [XLEN-1:0]  win_data;
    logic             wr_en;

    logic             we3_q,  we3_d;
    logic [AW-1:0]    a3_q,   a3_d;
    logic [XLEN-1:0]  wd3_q,  wd3_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;

    rr_arbiter2 #(
        .PRIO_MODE (PRIO_MODE)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i ({req1_valid, req0_valid}),
        .gnt_o (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    always_comb begin
        win_addr = req0_addr;
        win_data = req0_data;
        if (gnt[1]) begin
            win_addr = req1_addr;
            win_data = req1_data;
        end
    end

    // An x0 grant still consumes the handshake but leaves the write port idle.
    assign wr_en = (gnt != 2'b00) && (win_addr != X0_ADDR);

    always_comb begin
        we3_d = wr_en;
        a3_d  = wr_en ? win_addr : a3_q;
        wd3_d = wr_en ? win_data : wd3_q;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (req0_valid && req1_valid && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we3_q <= 1'b0;
            a3_q  <= '0;
            wd3_q <= '0;
            cnt_q <= '0;
        end else begin
            we3_q <= we3_d;
            a3_q  <= a3_d;
            wd3_q <= wd3_d;
            cnt_q <= cnt_d;
        end
    end

    // Bypass the write being committed this cycle so readers never see stale data.
    assign fwd_rd1 = (we3_q && (rd_a1 == a3_q) && (rd_a1 != X0_ADDR)) ? wd3_q : rf_rd1;
    assign fwd_rd2 = (we3_q && (rd_a2 == a3_q) && (rd_a2 != X0_ADDR)) ? wd3_q : rf_rd2;

    assign we3          = we3_q;
    assign a3           = a3_q;
    assign wd3          = wd3_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: round-robin instance with a register-file
// model, plus a fixed-priority instance with a narrow counter for saturation.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        v0, v1;
    logic [4:0]  a0, a1, ra1, ra2;
    logic [31:0] d0, d1, rf1, rf2;

    logic        r0_a, r1_a, we3_a;
    logic [4:0]  a3_a;
    logic [31:0] wd3_a, f1_a, f2_a;
    logic [15:0] cnt_a;

    logic        r0_b, r1_b, we3_b;
    logic [4:0]  a3_b;
    logic [31:0] wd3_b, f1_b, f2_b;
    logic [2:0]  cnt_b;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.XLEN(32), .AW(5), .PRIO_MODE(0), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(r0_a),
        .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(r1_a),
        .we3(we3_a), .a3(a3_a), .wd3(wd3_a),
        .rd_a1(ra1), .rd_a2(ra2), .rf_rd1(rf1), .rf_rd2(rf2),
        .fwd_rd1(f1_a), .fwd_rd2(f2_a), .conflict_cnt(cnt_a)
    );

    regfile_wb_arbiter #(.XLEN(32), .AW(5), .PRIO_MODE(1), .CNT_W(3)) dut_fx (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(r0_b),
        .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(r1_b),
        .we3(we3_b), .a3(a3_b), .wd3(wd3_b),
        .rd_a1(ra1), .rd_a2(ra2), .rf_rd1(rf1), .rf_rd2(rf2),
        .fwd_rd1(f1_b), .fwd_rd2(f2_b), .conflict_cnt(cnt_b)
    );

    // Register file fed by the round-robin instance's write port.
    logic [31:0] rf_model [32];
    initial for (int i = 0; i < 32; i++) rf_model[i] = 32'h0;
    always @(posedge clk) if (we3_a) rf_model[a3_a] <= wd3_a;

    typedef struct {
        logic        v0; logic [4:0] a0; logic [31:0] d0;
        logic        v1; logic [4:0] a1; logic [31:0] d1;
        logic [4:0]  ra1; logic [31:0] rf1;
        logic [4:0]  ra2; logic [31:0] rf2;
        logic        er0, er1;
        logic [31:0] ef1, ef2;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    vec_t tbl [10];
    wr_t  sb_q [$];
    logic [4:0]  held_a;
    logic [31:0] held_d;
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic vv0, input logic [4:0] aa0, input logic [31:0] dd0,
                                input logic vv1, input logic [4:0] aa1, input logic [31:0] dd1,
                                input logic [4:0] rra1, input logic [31:0] rrf1,
                                input logic [4:0] rra2, input logic [31:0] rrf2,
                                input logic eer0, input logic eer1,
                                input logic [31:0] eef1, input logic [31:0] eef2);
        vec_t v;
        v.v0 = vv0; v.a0 = aa0; v.d0 = dd0; v.v1 = vv1; v.a1 = aa1; v.d1 = dd1;
        v.ra1 = rra1; v.rf1 = rrf1; v.ra2 = rra2; v.rf2 = rrf2;
        v.er0 = eer0; v.er1 = eer1; v.ef1 = eef1; v.ef2 = eef2;
        return v;
    endfunction

    task automatic pop_check(input int k);
        wr_t e;
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 1, 0);
            return;
        end
        e = sb_q.pop_front();
        chk($sformatf("we3[%0d]", k), we3_a, e.we);
        chk($sformatf("a3[%0d]", k), a3_a, e.a);
        chk($sformatf("wd3[%0d]", k), wd3_a, e.d);
    endtask

    initial begin
        tbl[0] = mk(1, 1, 32'h11,       1, 2, 32'h22,   31, 32'h100,  31, 32'h200, 1, 0, 32'h100,  32'h200);
        tbl[1] = mk(1, 3, 32'h33,       1, 2, 32'h22,    1, 32'h101,   2, 32'hBB,  0, 1, 32'h11,   32'hBB);
        tbl[2] = mk(1, 3, 32'h33,       1, 4, 32'h44,   31, 32'h102,   2, 32'h202, 1, 0, 32'h102,  32'h22);
        tbl[3] = mk(1, 5, 32'hDEADBEEF, 1, 4, 32'h44,    3, 32'h0,    31, 32'h203, 0, 1, 32'h33,   32'h203);
        tbl[4] = mk(1, 5, 32'hDEADBEEF, 0, 0, 32'h0,     4, 32'h104,   0, 32'h204, 1, 0, 32'h44,   32'h204);
        tbl[5] = mk(0, 0, 32'h0,        1, 0, 32'h1234,  5, 32'h0,    31, 32'h205, 0, 1, 32'hDEADBEEF, 32'h205);
        tbl[6] = mk(0, 0, 32'h0,        0, 0, 32'h0,     0, 32'hCAFE,  5, 32'h206, 0, 0, 32'hCAFE, 32'h206);
        tbl[7] = mk(1, 7, 32'hA5A5A5A5, 0, 0, 32'h0,    31, 32'h107,  31, 32'h207, 1, 0, 32'h107,  32'h207);
        tbl[8] = mk(0, 0, 32'h0,        0, 0, 32'h0,     8, 32'h5555,  7, 32'h0,   0, 0, 32'h5555, 32'hA5A5A5A5);
        tbl[9] = mk(0, 0, 32'h0,        0, 0, 32'h0,     7, 32'h109,   7, 32'h209, 0, 0, 32'h109,  32'h209);

        rst = 1'b1; v0 = 0; v1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;
        ra1 = 0; ra2 = 0; rf1 = 0; rf2 = 0;
        held_a = 0; held_d = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we3", we3_a, 0);
        chk("rst_a3", a3_a, 0);
        chk("rst_wd3", wd3_a, 0);
        chk("rst_cnt", cnt_a, 0);
        chk("rst_ready0", r0_a, 0);
        chk("rst_ready1", r1_a, 0);
        rst = 1'b0;

        for (int k = 0; k < 10; k++) begin
            wr_t e;
            if (k > 0) pop_check(k - 1);
            v0 = tbl[k].v0; a0 = tbl[k].a0; d0 = tbl[k].d0;
            v1 = tbl[k].v1; a1 = tbl[k].a1; d1 = tbl[k].d1;
            ra1 = tbl[k].ra1; rf1 = tbl[k].rf1; ra2 = tbl[k].ra2; rf2 = tbl[k].rf2;
            #4;
            chk($sformatf("ready0[%0d]", k), r0_a, tbl[k].er0);
            chk($sformatf("ready1[%0d]", k), r1_a, tbl[k].er1);
            chk($sformatf("fwd1[%0d]", k), f1_a, tbl[k].ef1);
            chk($sformatf("fwd2[%0d]", k), f2_a, tbl[k].ef2);
            chk($sformatf("fx_ready0[%0d]", k), r0_b, tbl[k].v0);
            chk($sformatf("fx_ready1[%0d]", k), r1_b, tbl[k].v1 && !tbl[k].v0);
            e.we = 1'b0;
            if (tbl[k].er0 && tbl[k].a0 != 0) begin
                e.we = 1'b1; held_a = tbl[k].a0; held_d = tbl[k].d0;
            end else if (tbl[k].er1 && tbl[k].a1 != 0) begin
                e.we = 1'b1; held_a = tbl[k].a1; held_d = tbl[k].d1;
            end
            e.a = held_a; e.d = held_d;
            sb_q.push_back(e);
            @(posedge clk);
            #1;
        end
        pop_check(9);
        chk("cnt_rr", cnt_a, 4);
        chk("cnt_fx", cnt_b, 4);
        chk("rf_x2", rf_model[2], 32'h22);
        chk("rf_x5", rf_model[5], 32'hDEADBEEF);
        chk("rf_x7", rf_model[7], 32'hA5A5A5A5);
        chk("rf_x0", rf_model[0], 32'h0);

        // Write accepted in the reset cycle must be dropped.
        v0 = 1; a0 = 3; d0 = 32'h3333; v1 = 0; rst = 1'b1;
        #4;
        chk("rst_grant_ready0", r0_a, 1);
        @(posedge clk); #1;
        rst = 1'b0; v0 = 0;
        chk("rst_drop_we3", we3_a, 0);
        chk("rst_drop_a3", a3_a, 0);
        chk("rst_drop_cnt", cnt_a, 0);
        @(posedge clk); #1;
        chk("rst_drop_x3", rf_model[3], 32'h33);

        // Same destination from both requesters: grant order decides the winner.
        v0 = 1; a0 = 9; d0 = 32'h1; v1 = 1; a1 = 9; d1 = 32'h2;
        #4;
        chk("same_r0", r0_a, 1);
        chk("same_r1", r1_a, 0);
        @(posedge clk); #1;
        v0 = 0;
        chk("same_we3_1", we3_a, 1);
        chk("same_wd3_1", wd3_a, 32'h1);
        #4;
        chk("same_r1_second", r1_a, 1);
        @(posedge clk); #1;
        v1 = 0;
        chk("same_wd3_2", wd3_a, 32'h2);
        @(posedge clk); #1;
        chk("same_x9", rf_model[9], 32'h2);

        // Counter saturation on the narrow instance.
        v0 = 1; a0 = 0; d0 = 0; v1 = 1; a1 = 0; d1 = 0;
        repeat (8) @(posedge clk);
        #1;
        v0 = 0; v1 = 0;
        chk("sat_cnt_fx", cnt_b, 7);
        chk("sat_cnt_rr", cnt_a, 9);
        @(posedge clk); #1;
        chk("sat_hold_fx", cnt_b, 7);
        chk("sat_x0_we3", we3_a, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
